chunked_subtractor: RTL and testbench

CHUNKED_SUBTRACTOR -- requirements
Module: chunked_subtractor

---
 rtl/sub_pkg.sv | 17 +
 rtl/chunk_subtractor.sv | 19 +
 rtl/chunked_subtractor.sv | 119 +++++++++++
 tb/tb_chunked_subtractor.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared encodings for the chunked subtractor: operation modes and FSM states.
package sub_pkg;

  typedef enum logic [1:0] {
    MODE_SUB = 2'b00,
    MODE_SBC = 2'b01,
    MODE_CMP = 2'b10,
    MODE_NEG = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/chunk_subtractor.sv
// Combinational CHUNK-bit subtract with borrow-in/borrow-out; one slice of the wide operation.
module chunk_subtractor #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             bin_i,
  output logic [CHUNK-1:0] diff_o,
  output logic             bout_o
);

  logic [CHUNK:0] full;

  // The extra top bit of the widened difference is the borrow out of this slice.
  assign full   = {1'b0, a_i} - {1'b0, b_i} - {{CHUNK{1'b0}}, bin_i};
  assign diff_o = full[CHUNK-1:0];
  assign bout_o = full[CHUNK];

endmodule

// File: rtl/chunked_subtractor.sv
// Multi-cycle subtractor: processes CHUNK bits per clock, LSB first, and
// publishes the full difference and flags only when the last chunk completes.
module chunked_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e           state_q;
  mode_e            mode_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] opA_q, opB_q, res_q, diff_q;
  logic             borrow_q, aMsb_q, bMsb_q, nonZero_q;
  logic             bout_q, zero_q, ovf_q;

  logic [CHUNK-1:0] chunkDiff;
  logic             chunkBout;
  logic [WIDTH-1:0] chunkExt, res_d;
  logic             ovf_d, zero_d, accept;

  chunk_subtractor #(.CHUNK(CHUNK)) u_chunk (
    .a_i    (opA_q[CHUNK-1:0]),
    .b_i    (opB_q[CHUNK-1:0]),
    .bin_i  (borrow_q),
    .diff_o (chunkDiff),
    .bout_o (chunkBout)
  );

  // Each new chunk enters the result from the top, so after N steps it is fully aligned.
  always_comb begin
    chunkExt = WIDTH'(chunkDiff);
    res_d    = (res_q >> CHUNK) | (chunkExt << (WIDTH - CHUNK));
    ovf_d    = (aMsb_q != bMsb_q) && (chunkDiff[CHUNK-1] != aMsb_q);
    zero_d   = !(nonZero_q || (|chunkDiff));
    accept   = start && (state_q != ST_BUSY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_SUB;
      cnt_q     <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      res_q     <= '0;
      diff_q    <= '0;
      borrow_q  <= 1'b0;
      aMsb_q    <= 1'b0;
      bMsb_q    <= 1'b0;
      nonZero_q <= 1'b0;
      bout_q    <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_BUSY: begin
          opA_q     <= opA_q >> CHUNK;
          opB_q     <= opB_q >> CHUNK;
          borrow_q  <= chunkBout;
          res_q     <= res_d;
          nonZero_q <= nonZero_q || (|chunkDiff);
          if (cnt_q == LAST) begin
            state_q <= ST_DONE;
            cnt_q   <= '0;
            if (mode_q != MODE_CMP) diff_q <= res_d;
            bout_q  <= chunkBout;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; NEG forces the minuend to zero.
          if (accept) begin
            state_q   <= ST_BUSY;
            mode_q    <= mode_e'(mode);
            cnt_q     <= '0;
            opA_q     <= (mode == MODE_NEG) ? '0 : a;
            opB_q     <= b;
            aMsb_q    <= (mode == MODE_NEG) ? 1'b0 : a[WIDTH-1];
            bMsb_q    <= b[WIDTH-1];
            borrow_q  <= (mode == MODE_SBC) && bin;
            nonZero_q <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign done = (state_q == ST_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_subtractor.sv
// Directed checks of the chunked subtractor: arithmetic, flags, latency, start handling and reset abort.
module tb_chunked_subtractor;
  import sub_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic [1:0]  mode;
  logic [15:0] a, b;
  logic        bin;
  logic        busy, done, bout, zero, ovf;
  logic [15:0] diff;
  logic        busy2, done2, bout2, zero2, ovf2;
  logic [15:0] diff2;

  int nAsserts = 0;
  int nFail    = 0;
  int lat;
  int doneSeen;

  always #5 clk = ~clk;

  chunked_subtractor #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
  );

  chunked_subtractor #(.WIDTH(16), .CHUNK(16)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode), .a(a), .b(b), .bin(bin),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2), .zero(zero2), .ovf(ovf2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Counts edges until done rises, giving up after a fixed budget.
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [15:0] av, input logic [15:0] bv,
                               input logic bi, output int cycles);
    mode = m; a = av; b = bv; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(cycles);
  endtask

  initial begin
    $display("[TB] chunked_subtractor directed run");
    rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 2'b00; a = '0; b = '0; bin = 1'b0;
    #12;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_diff", diff, 0);
    checkOutput("rst_flags", {bout, zero, ovf}, 0);
    checkOutput("rst_dut2", {busy2, done2, diff2}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(MODE_SUB, 16'd10, 16'd5, 1'b0, lat);
    checkOutput("sub10_5_lat", lat, 4);
    checkOutput("sub10_5_diff", diff, 16'd5);
    checkOutput("sub10_5_flags", {bout, zero, ovf}, 3'b000);
    checkOutput("sub10_5_busy", busy, 0);
    @(posedge clk); #1;
    checkOutput("sub10_5_pulse", done, 0);

    applyStimulus(MODE_SBC, 16'd1, 16'd2, 1'b1, lat);
    checkOutput("sbc_diff", diff, 16'd65534);
    checkOutput("sbc_flags", {bout, zero, ovf}, 3'b100);
    @(posedge clk); #1;

    applyStimulus(MODE_SUB, 16'd12345, 16'd54321, 1'b1, lat);
    checkOutput("sub_big_diff", diff, 16'd23560);
    checkOutput("sub_big_flags", {bout, zero, ovf}, 3'b100);
    @(posedge clk); #1;

    applyStimulus(MODE_SUB, 16'h8000, 16'h0001, 1'b0, lat);
    checkOutput("ovf_diff", diff, 16'h7FFF);
    checkOutput("ovf_flags", {bout, zero, ovf}, 3'b001);
    @(posedge clk); #1;

    applyStimulus(MODE_CMP, 16'd100, 16'd100, 1'b0, lat);
    checkOutput("cmp_lat", lat, 4);
    checkOutput("cmp_diff_kept", diff, 16'h7FFF);
    checkOutput("cmp_flags", {bout, zero, ovf}, 3'b010);
    @(posedge clk); #1;

    applyStimulus(MODE_NEG, 16'h1234, 16'd1, 1'b0, lat);
    checkOutput("neg_diff", diff, 16'hFFFF);
    checkOutput("neg_flags", {bout, zero, ovf}, 3'b100);
    @(posedge clk); #1;

    // Start pulse and operand changes mid-operation must not disturb it.
    mode = MODE_SUB; a = 16'd20; b = 16'd3; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 16'd999; b = 16'd1; mode = MODE_NEG; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(lat);
    checkOutput("midbusy_lat", lat + 2, 4);
    checkOutput("midbusy_diff", diff, 16'd17);
    @(posedge clk); #1;
    checkOutput("midbusy_noqueue", {busy, done}, 2'b00);

    // Back-to-back: start during the DONE cycle is taken immediately.
    applyStimulus(MODE_SUB, 16'd50, 16'd8, 1'b0, lat);
    checkOutput("b2b_first_diff", diff, 16'd42);
    mode = MODE_SUB; a = 16'd7; b = 16'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("b2b_busy", {busy, done}, 2'b10);
    waitDone(lat);
    checkOutput("b2b_lat", lat, 4);
    checkOutput("b2b_diff", diff, 16'hFFFE);
    checkOutput("b2b_bout", bout, 1);
    @(posedge clk); #1;

    // Reset while chunk 2 is in flight.
    mode = MODE_SUB; a = 16'd9; b = 16'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy_done", {busy, done}, 2'b00);
    checkOutput("abort_diff", diff, 0);
    checkOutput("abort_flags", {bout, zero, ovf}, 3'b000);
    doneSeen = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) doneSeen++;
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) doneSeen++;
    end
    checkOutput("abort_no_done", doneSeen, 0);

    applyStimulus(MODE_SUB, 16'd3, 16'd1, 1'b0, lat);
    checkOutput("fresh_lat", lat, 4);
    checkOutput("fresh_diff", diff, 16'd2);
    @(posedge clk); #1;

    // Single-chunk instance completes one edge after acceptance.
    mode = MODE_SUB; a = 16'd1000; b = 16'd1; bin = 1'b0; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    lat = 0;
    while (done2 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("w16_lat", lat, 1);
    checkOutput("w16_diff", diff2, 16'd999);
    checkOutput("w16_flags", {bout2, zero2, ovf2}, 3'b000);
    @(posedge clk); #1;
    checkOutput("w16_pulse", {busy2, done2}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
